// File: rtl/csr_spmv_lanes_if.sv
// Signal bundle for csr_spmv_lanes: pass control, the three CSR memory read ports and the result stream.
// master is the engine side; slave is the memory / result-store side.
interface csr_spmv_lanes_if #(
  parameter int DW     = 32,
  parameter int AW     = 64,
  parameter int LANES  = 2,
  parameter int NNZ_AW = 14,
  parameter int ROW_AW = 10,
  parameter int COL_AW = 10
);
  logic                start;
  logic [ROW_AW-1:0]   num_rows;
  logic                busy;
  logic                done;
  logic [ROW_AW-1:0]   row_addr;
  logic [NNZ_AW-1:0]   row_data;
  logic [NNZ_AW-1:0]   nnz_addr;
  logic [DW-1:0]       val_data;
  logic [COL_AW-1:0]   col_data;
  logic [COL_AW-1:0]   x_addr;
  logic [LANES*DW-1:0] x_data;
  logic                res_valid;
  logic                res_ready;
  logic [ROW_AW-1:0]   res_row;
  logic [LANES*AW-1:0] res_data;
  logic                res_zero;

  modport master (
    input  start, num_rows, row_data, val_data, col_data, x_data, res_ready,
    output busy, done, row_addr, nnz_addr, x_addr, res_valid, res_row, res_data, res_zero
  );

  modport slave (
    output start, num_rows, row_data, val_data, col_data, x_data, res_ready,
    input  busy, done, row_addr, nnz_addr, x_addr, res_valid, res_row, res_data, res_zero
  );
endinterface

// File: rtl/csr_spmv_lanes.sv
// CSR sparse-matrix x LANES dense-vector engine: one MAC per nonzero per lane, one result per row
// over a valid/ready stream, with explicit zero results for empty (or malformed) rows.
module csr_spmv_lanes #(
  parameter int DW     = 32,
  parameter int AW     = 64,
  parameter int LANES  = 2,
  parameter int NNZ_AW = 14,
  parameter int ROW_AW = 10,
  parameter int COL_AW = 10
) (
  input  logic             clk,
  input  logic             rst,
  csr_spmv_lanes_if.master bus
);
  localparam int PW = 2 * DW;
  localparam logic [NNZ_AW-1:0] NNZ_ZERO = {NNZ_AW{1'b0}};
  localparam logic [NNZ_AW-1:0] NNZ_ONE  = {{(NNZ_AW-1){1'b0}}, 1'b1};
  localparam logic [ROW_AW-1:0] ROW_ZERO = {ROW_AW{1'b0}};
  localparam logic [ROW_AW-1:0] ROW_ONE  = {{(ROW_AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]     ACC_ZERO = {AW{1'b0}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    P0    = 3'd1,
    P0W   = 3'd2,
    PTR   = 3'd3,
    PTRW  = 3'd4,
    MAC   = 3'd5,
    DRAIN = 3'd6,
    EMIT  = 3'd7
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic                  busy_r;
  logic                  done_r;
  logic                  res_valid_r;
  logic                  res_zero_r;
  logic [ROW_AW-1:0]     res_row_r;
  logic [LANES*AW-1:0]   res_data_r;
  logic [ROW_AW-1:0]     row_addr_r;
  logic [NNZ_AW-1:0]     nnz_addr_r;
  logic [ROW_AW-1:0]     num_rows_r;
  logic [ROW_AW-1:0]     row_r;
  logic [NNZ_AW-1:0]     lo_r;
  logic [NNZ_AW-1:0]     hi_r;
  logic                  drain_r;
  logic                  v1_r;
  logic                  v2_r;
  logic signed [DW-1:0]  val_r;
  logic signed [AW-1:0]  acc_r      [LANES];
  logic signed [AW-1:0]  acc_next_s [LANES];
  logic signed [DW-1:0]  x_lane_s   [LANES];
  logic signed [PW-1:0]  prod_s     [LANES];
  logic [LANES*AW-1:0]   acc_pack_s;
  logic [ROW_AW:0]       row_inc_s;
  logic                  more_rows_s;
  logic                  empty_s;
  logic                  last_issue_s;
  logic                  handshake_s;
  logic                  num_rows_zero_s;

  assign row_inc_s       = {1'b0, row_r} + {1'b0, ROW_ONE};
  assign more_rows_s     = (row_inc_s < {1'b0, num_rows_r});
  // hi <= lo also absorbs malformed pointers (hi < lo) as an empty row
  assign empty_s         = (bus.row_data <= lo_r);
  assign last_issue_s    = (nnz_addr_r == (hi_r - NNZ_ONE));
  assign handshake_s     = res_valid_r & bus.res_ready;
  assign num_rows_zero_s = (bus.num_rows == ROW_ZERO);

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res_zero  = res_zero_r;
  assign bus.res_row   = res_row_r;
  assign bus.res_data  = res_data_r;
  assign bus.row_addr  = row_addr_r;
  assign bus.nnz_addr  = nnz_addr_r;
  assign bus.x_addr    = bus.col_data;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start && !num_rows_zero_s) state_next_s = P0;
        else                               state_next_s = IDLE;
      end
      P0:   state_next_s = P0W;
      P0W:  state_next_s = PTR;
      PTR:  state_next_s = PTRW;
      PTRW: begin
        if (empty_s) state_next_s = EMIT;
        else         state_next_s = MAC;
      end
      MAC: begin
        if (last_issue_s) state_next_s = DRAIN;
        else              state_next_s = MAC;
      end
      DRAIN: begin
        if (drain_r) state_next_s = EMIT;
        else         state_next_s = DRAIN;
      end
      EMIT: begin
        if (handshake_s && more_rows_s) state_next_s = PTR;
        else if (handshake_s)           state_next_s = IDLE;
        else                            state_next_s = EMIT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Per-lane product and accumulator update; PTRW clears ahead of a new row
  always_comb begin
    acc_pack_s = {(LANES*AW){1'b0}};
    for (int i = 0; i < LANES; i++) begin
      x_lane_s[i] = bus.x_data[i*DW +: DW];
      prod_s[i]   = PW'(val_r) * PW'(x_lane_s[i]);
      if (state_r == PTRW) begin
        acc_next_s[i] = ACC_ZERO;
      end else if (v2_r) begin
        acc_next_s[i] = acc_r[i] + AW'(prod_s[i]);
      end else begin
        acc_next_s[i] = acc_r[i];
      end
      acc_pack_s[i*AW +: AW] = acc_next_s[i];
    end
  end

  // Read pipeline: v1 marks val/col arriving, v2 marks x arriving alongside the registered value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_r  <= 1'b0;
      v2_r  <= 1'b0;
      val_r <= {DW{1'b0}};
      for (int i = 0; i < LANES; i++) acc_r[i] <= ACC_ZERO;
    end else begin
      v1_r <= (state_r == MAC);
      v2_r <= v1_r;
      if (v1_r) val_r <= bus.val_data;
      else      val_r <= val_r;
      for (int i = 0; i < LANES; i++) acc_r[i] <= acc_next_s[i];
    end
  end

  // Row sequencing, memory addresses and the held result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      res_valid_r <= 1'b0;
      res_zero_r  <= 1'b0;
      res_row_r   <= ROW_ZERO;
      res_data_r  <= {(LANES*AW){1'b0}};
      row_addr_r  <= ROW_ZERO;
      nnz_addr_r  <= NNZ_ZERO;
      num_rows_r  <= ROW_ZERO;
      row_r       <= ROW_ZERO;
      lo_r        <= NNZ_ZERO;
      hi_r        <= NNZ_ZERO;
      drain_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            num_rows_r <= bus.num_rows;
            row_r      <= ROW_ZERO;
            row_addr_r <= ROW_ZERO;
            if (num_rows_zero_s) done_r <= 1'b1;
            else                 busy_r <= 1'b1;
          end
        end
        P0W: begin
          lo_r       <= bus.row_data;
          row_addr_r <= ROW_ONE;
        end
        PTRW: begin
          hi_r <= bus.row_data;
          if (empty_s) begin
            res_valid_r <= 1'b1;
            res_zero_r  <= 1'b1;
            res_data_r  <= {(LANES*AW){1'b0}};
            res_row_r   <= row_r;
          end else begin
            nnz_addr_r <= lo_r;
          end
        end
        MAC: begin
          drain_r <= 1'b0;
          if (!last_issue_s) nnz_addr_r <= nnz_addr_r + NNZ_ONE;
        end
        DRAIN: begin
          if (drain_r) begin
            drain_r     <= 1'b0;
            res_valid_r <= 1'b1;
            res_zero_r  <= 1'b0;
            res_data_r  <= acc_pack_s;
            res_row_r   <= row_r;
          end else begin
            drain_r <= 1'b1;
          end
        end
        EMIT: begin
          if (handshake_s) begin
            res_valid_r <= 1'b0;
            res_zero_r  <= 1'b0;
            lo_r        <= hi_r;
            row_r       <= row_inc_s[ROW_AW-1:0];
            if (more_rows_s) begin
              row_addr_r <= row_inc_s[ROW_AW-1:0] + ROW_ONE;
            end else begin
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule
